// File: rtl/gecko_reg_scoreboard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gecko_reg_scoreboard_pkg : register-status type, address type and count->status map
// Revision: 1.0
// ----------------------------------------------------------------------------
package gecko_reg_scoreboard_pkg;

    // rv32 architectural register address
    typedef logic [4:0] gecko_reg_addr_t;

    typedef enum logic [1:0] {
        GECKO_REG_STATUS_VALID   = 2'd0,
        GECKO_REG_STATUS_PENDING = 2'd1,
        GECKO_REG_STATUS_FULL    = 2'd2
    } gecko_reg_status_t;

    // Counters up to 4 bits are zero-extended by the caller; full_val is the all-ones value.
    function automatic gecko_reg_status_t count_to_status(input logic [3:0] cnt,
                                                          input logic [3:0] full_val);
        gecko_reg_status_t st;
        if (cnt == 4'd0)
            st = GECKO_REG_STATUS_VALID;
        else if (cnt == full_val)
            st = GECKO_REG_STATUS_FULL;
        else
            st = GECKO_REG_STATUS_PENDING;
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gecko_reg_scoreboard_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gecko_reg_scoreboard_counter : saturating pending-write counter for one register
// Revision: 1.0
// ----------------------------------------------------------------------------
module gecko_reg_scoreboard_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             underflow
);
    localparam logic [WIDTH-1:0] C_FULL = '1;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d   = count_q;
        underflow = dec && (count_q == '0);
        unique case ({inc, dec})
            2'b10: if (count_q != C_FULL) count_d = count_q + C_ONE;
            2'b01: if (count_q != '0)     count_d = count_q - C_ONE;
            // Write-back resolves first: an empty counter underflows, then the issue lands.
            2'b11: if (count_q == '0)     count_d = C_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/gecko_reg_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gecko_reg_scoreboard : per-register pending-write tracking for decode hazard checks
// Revision: 1.0
// ----------------------------------------------------------------------------
module gecko_reg_scoreboard
    import gecko_reg_scoreboard_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  gecko_reg_addr_t   issue_rd,
    input  logic              wb_valid,
    input  gecko_reg_addr_t   wb_rd,
    input  gecko_reg_addr_t   rs1_addr,
    input  gecko_reg_addr_t   rs2_addr,
    input  gecko_reg_addr_t   rd_addr,
    output gecko_reg_status_t rs1_status,
    output gecko_reg_status_t rs2_status,
    output gecko_reg_status_t rd_status,
    output logic              busy,
    output logic              error
);
    localparam logic [COUNTER_WIDTH-1:0] C_FULL = '1;

    logic [COUNTER_WIDTH-1:0] cnt [32];
    logic [31:1]              uf;
    logic [31:1]              nonzero;
    logic                     issue_acc;
    logic                     error_q;

    assign cnt[0]      = '0;
    assign issue_ready = (issue_rd == 5'd0) || (cnt[issue_rd] != C_FULL);
    assign issue_acc   = issue_valid && issue_ready;

    for (genvar i = 1; i < 32; i++) begin : g_cnt
        gecko_reg_scoreboard_counter #(
            .WIDTH (COUNTER_WIDTH)
        ) u_counter (
            .clk       (clk),
            .rst       (rst),
            .inc       (issue_acc && (issue_rd == 5'(i))),
            .dec       (wb_valid && (wb_rd == 5'(i))),
            .count     (cnt[i]),
            .underflow (uf[i])
        );
        assign nonzero[i] = (cnt[i] != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            error_q <= 1'b0;
        else if (|uf)
            error_q <= 1'b1;
    end

    assign error      = error_q;
    assign busy       = |nonzero;
    assign rs1_status = count_to_status(4'(cnt[rs1_addr]), 4'(C_FULL));
    assign rs2_status = count_to_status(4'(cnt[rs2_addr]), 4'(C_FULL));
    assign rd_status  = count_to_status(4'(cnt[rd_addr]),  4'(C_FULL));

endmodule
`default_nettype wire

// File: tb/tb_gecko_reg_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gecko_reg_scoreboard : directed scenarios plus random traffic vs. a counter model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_gecko_reg_scoreboard;
    import gecko_reg_scoreboard_pkg::*;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [4:0]        issue_rd = '0;
    logic              wb_valid = 1'b0;
    logic [4:0]        wb_rd = '0;
    logic [4:0]        rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    gecko_reg_status_t rs1_status, rs2_status, rd_status;
    logic              busy, error;

    int model [32];
    bit m_err;
    int n_vec = 0;
    int n_bad = 0;

    gecko_reg_scoreboard #(.COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_status(rs1_status), .rs2_status(rs2_status), .rd_status(rd_status),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_st(input int c);
        if (c == 0)    return 2'd0;
        if (c == MAXC) return 2'd2;
        return 2'd1;
    endfunction

    function automatic bit model_busy();
        for (int r = 1; r < 32; r++) if (model[r] != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all();
        chk("rs1_status", rs1_status, exp_st(model[rs1_addr]));
        chk("rs2_status", rs2_status, exp_st(model[rs2_addr]));
        chk("rd_status",  rd_status,  exp_st(model[rd_addr]));
        chk("issue_ready", issue_ready, (issue_rd == 0) || (model[issue_rd] != MAXC));
        chk("busy", busy, model_busy());
        chk("error", error, m_err);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input bit iv, input int ird, input bit wv, input int wrd);
        bit acc;
        issue_valid = iv; issue_rd = 5'(ird);
        wb_valid    = wv; wb_rd    = 5'(wrd);
        #1;
        check_all();
        acc = iv && (ird == 0 || model[ird] != MAXC);
        @(posedge clk);
        if (wv && wrd != 0) begin
            if (model[wrd] == 0) begin
                m_err = 1'b1;
                if (acc && ird == wrd) model[wrd] = 1;
            end else if (!(acc && ird == wrd)) begin
                model[wrd]--;
            end
        end
        if (acc && ird != 0 && !(wv && wrd == ird)) model[ird]++;
        @(negedge clk);
        issue_valid = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        foreach (model[r]) model[r] = 0;
        m_err = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_ready", issue_ready, 1);
        chk("rst_rs1", rs1_status, GECKO_REG_STATUS_VALID);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single issue becomes visible after the edge.
        rs1_addr = 5'd5;
        step(1, 5, 0, 0);
        #1;
        chk("x5_pending", rs1_status, GECKO_REG_STATUS_PENDING);
        chk("x5_busy", busy, 1);

        // Saturation and release on x7.
        rd_addr = 5'd7;
        repeat (3) step(1, 7, 0, 0);
        #1;
        chk("x7_full", rd_status, GECKO_REG_STATUS_FULL);
        issue_rd = 5'd7; #1;
        chk("x7_ready_blocked", issue_ready, 0);
        issue_rd = 5'd8; #1;
        chk("x8_ready", issue_ready, 1);
        step(1, 7, 0, 0);
        step(0, 0, 1, 7);
        #1;
        chk("x7_pending", rd_status, GECKO_REG_STATUS_PENDING);
        issue_rd = 5'd7; #1;
        chk("x7_ready_again", issue_ready, 1);

        // Same-register issue and write-back cancel out.
        @(negedge clk);
        do_reset();
        rd_addr = 5'd3;
        step(1, 3, 0, 0);
        step(1, 3, 1, 3);
        #1;
        chk("x3_pending", rd_status, GECKO_REG_STATUS_PENDING);
        chk("x3_no_err", error, 0);

        // Underflow is sticky; x0 traffic is inert.
        rs1_addr = 5'd9;
        step(0, 0, 1, 9);
        #1;
        chk("x9_err", error, 1);
        repeat (10) step(0, 0, 0, 0);
        #1;
        chk("x9_err_sticky", error, 1);
        chk("x9_valid", rs1_status, GECKO_REG_STATUS_VALID);
        rs2_addr = 5'd0;
        step(1, 0, 1, 0);
        issue_rd = 5'd0; #1;
        chk("x0_ready", issue_ready, 1);
        chk("x0_valid", rs2_status, GECKO_REG_STATUS_VALID);

        // Fill every register, then reset mid-stream with an issue in flight.
        @(negedge clk);
        do_reset();
        for (int r = 1; r < 32; r++) step(1, r, 0, 0);
        #1;
        chk("all_busy", busy, 1);
        issue_valid = 1'b1; issue_rd = 5'd10; wb_valid = 1'b1; wb_rd = 5'd2;
        rs1_addr = 5'd10; rs2_addr = 5'd2; rd_addr = 5'd31;
        rst = 1'b0;
        foreach (model[r]) model[r] = 0;
        m_err = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_rs1", rs1_status, GECKO_REG_STATUS_VALID);
        chk("mid_rst_rd", rd_status, GECKO_REG_STATUS_VALID);
        @(posedge clk); #1;
        chk("mid_rst_hold", rs1_status, GECKO_REG_STATUS_VALID);
        @(negedge clk);
        issue_valid = 1'b0; wb_valid = 1'b0;
        rst = 1'b1;
        rs1_addr = 5'd4;
        step(1, 4, 0, 0);
        #1;
        chk("x4_after_rst", rs1_status, GECKO_REG_STATUS_PENDING);

        // Random traffic concentrated on a few registers so counters saturate.
        @(negedge clk);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int ird, wrd;
            ird = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            wrd = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5));
            rs1_addr = 5'($urandom_range(0, 6));
            rs2_addr = 5'($urandom_range(0, 31));
            rd_addr  = 5'($urandom_range(0, 6));
            if (n == 1500) begin
                @(negedge clk);
                do_reset();
            end
            step(bit'($urandom_range(0, 1)), ird, ($urandom_range(0, 2) == 0), wrd);
        end
        #1;
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
